fact_ctrl: RTL
==============

# fact_ctrl

Sequencing controller and datapath for the memory-mapped factorial accelerator. It captures the operand written to the accelerator's n register and a one-cycle start pulse derived from a write to its go register. It then computes n! iteratively with a down-counter and a multiply-accumulate register. Status (busy/done/err) and the 32-bit result are presented to the accelerator's read mux, which selects them through the existing 2-bit read select.

## Interface
Parameters:
- `NW`, 4: operand width (n is 0..15).
- `RW`, 32: result width.
- `NMAX`, 12: largest n whose factorial fits in `RW` bits. A larger n is an error.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle request to begin a computation.
- `n`, input, `NW`: operand, sampled only on the cycle `start` is accepted.
- `busy`, output, 1: a computation is in progress.
- `done`, output, 1: sticky completion flag.
- `err`, output, 1: sticky error flag; the last request had n > `NMAX`.
- `result`, output, `RW`: last computed factorial. Held until the next accepted start.
- `irq`, output, 1: present only with `FACT_IRQ_EN`.
- `irq_clr`, input, 1: present only with `FACT_IRQ_EN`.

## Operation
- Internal registers:
  - `state` ∈ {IDLE, RUN}.
  - `cnt[NW-1:0]`.
  - `prod[RW-1:0]`.
  - Output registers `busy`, `done`, `err`, `result`.
- Reset (async assert, sync release) drives:
  - state=IDLE, cnt=0, prod=0.
  - busy=0, done=0, err=0, result=0, irq=0.
- IDLE, `start`=1, n ≤ `NMAX`:
  - cnt←n, prod←1.
  - busy←1, done←0, err←0, result←0.
  - state←RUN.
- IDLE, `start`=1, n > `NMAX`:
  - err←1, done←1, result←0, busy stays 0.
  - state stays IDLE. No RUN cycles are spent.
- IDLE, `start`=0: all registers hold.
- RUN, cnt ≥ 2: prod←prod×cnt, truncated to `RW` bits (no overflow is possible for n ≤ `NMAX`), then cnt←cnt−1.
- RUN, cnt ≤ 1: result←prod, done←1, busy←0, state←IDLE.
  - n=0 and n=1 both yield result=1.
- `start` while in RUN is ignored. The operand is not re-sampled and the computation is not restarted. The bus side must poll `busy`/`done`.
- `done` and `err` stay asserted until the next accepted `start` or reset. They are never cleared by a read.
- The multiplier is a single-cycle combinational `RW`×`NW` product feeding `prod`. Only the low `RW` bits are kept.

## Timing
- Let E0 be the clock edge at which `start` is sampled high in IDLE.
- Valid n ≥ 2:
  - busy=1 from after E0.
  - Multiplies occur at E1..E(n−1).
  - done=1, busy=0 and result are valid after En.
- n ∈ {0,1}: done=1 after E1 (latency 1).
- n > `NMAX`: err=1 and done=1 after E0 (latency 0 beyond E0).
- Back-to-back requests: a `start` in the same cycle that done first reads 1 is accepted (state is IDLE). That new start clears done/err/result at the next edge.
- An asynchronous `rst_n` assertion during RUN immediately forces all reset values. The partial product is discarded and no done is produced.
- Outputs are registered; there are no combinational paths from `start` or `n` to any output.

## Configuration
- `FACT_IRQ_EN` defined:
  - Adds `irq` and `irq_clr`.
  - `irq` is set at the same edge where `done` transitions 0→1, on both the normal and the error path.
  - `irq` is cleared by `irq_clr`=1 at the next edge. If set and clear occur in the same cycle, set wins.
  - `irq` resets to 0.
- `FACT_IRQ_EN` undefined: both ports and all irq logic are absent. All other behaviour is identical.

## Test plan
- Reset, then start with n=5 → busy=1 after E0, done=1 after E5, result=120 (0x78), err=0.
- Start with n=0, then separately n=1 → each gives done after E1 and result=1.
- Start with n=12 → done after E12 and result=479001600 (0x1C8CFC00). Then n=13 → err=1, done=1 after E0, result=0, busy never 1.
- Start with n=6, pulse start with n=3 at E2 → the second start is ignored and result=720 after E6. A following start with n=3 is then accepted: done←0, result←0 at its edge, and result=6 three cycles later.
- Start with n=10, assert rst_n low at E4 → all outputs are 0 immediately. After release, a start with n=4 yields 24.
- With `FACT_IRQ_EN`: irq rises with done for n=3. Holding irq_clr high on the cycle of an n=0 completion keeps irq=1 (set wins). irq_clr alone then clears irq to 0.

Source files
------------

// File: rtl/fact_ctrl.sv
// fact_ctrl: sequencing controller and datapath for the factorial accelerator.
// Accepts a start pulse with operand n and computes n! iteratively. It uses a
// down-counter and a multiply-accumulate register. It reports busy/done/err
// status and holds the last result for the read mux.
// Optional feature macro: FACT_IRQ_EN adds an irq output and an irq_clr input.
module fact_ctrl #(
    parameter int NW   = 4,
    parameter int RW   = 32,
    parameter int NMAX = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef FACT_IRQ_EN
    input  logic          irq_clr,
    output logic          irq,
`endif
    input  logic [NW-1:0] n,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [RW-1:0] result
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [NW-1:0] NMAX_N = NW'(NMAX);
    localparam logic [NW-1:0] ONE_N  = NW'(1);

    state_t        state_q;
    logic [NW-1:0] cnt_q;
    logic [RW-1:0] prod_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [RW-1:0] result_q;
    logic [RW-1:0] prod_d;

`ifdef FACT_IRQ_EN
    logic irq_q;
    logic irqSet_d;

    // Raise irq exactly when done goes from 0 to 1, on either completion path
    always_comb begin
        irqSet_d = 1'b0;
        if (!done_q) begin
            if (state_q == IDLE && start && n > NMAX_N) begin
                irqSet_d = 1'b1;
            end else if (state_q == RUN && cnt_q <= ONE_N) begin
                irqSet_d = 1'b1;
            end
        end
    end

    // irq is sticky until cleared; a simultaneous set takes priority over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (irqSet_d) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

    // Single-cycle multiplier; only the low RW bits are kept
    always_comb begin
        prod_d = prod_q * RW'(cnt_q);
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (n > NMAX_N) begin
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                            result_q <= '0;
                        end else begin
                            cnt_q    <= n;
                            prod_q   <= RW'(1);
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            err_q    <= 1'b0;
                            result_q <= '0;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q > ONE_N) begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_q - ONE_N;
                    end else begin
                        result_q <= prod_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule
